uart_prog_loader: RTL and testbench
===================================

# uart_prog_loader

UART programming loader in the upg clock domain. Receives a framed byte stream on `upg_rx_i`, assembles 32-bit little-endian words, and emits one write strobe per word with a 15-bit word address. This is the producer of `upg_wen_o/upg_adr_o/upg_dat_o/upg_done_o`, which the CPU consumes for instruction-ROM and data-memory loading. It also returns 1-byte acknowledgements on `upg_tx_o`.

## Interface
- `CLKS_PER_BIT`, 78, `upg_clk_i` cycles per UART bit (10 MHz / 128000 baud); must be ≥ 4.
- `upg_clk_i` in 1: sole clock; all logic on its rising edge.
- `upg_rst_i` in 1: reset, synchronous, active-high.
- `upg_rx_i` in 1: UART RX, 8N1, idle high, asynchronous.
- `upg_clk_o` out 1: `upg_clk_i` passed through combinationally.
- `upg_wen_o` out 1: one-cycle write strobe per completed word.
- `upg_adr_o` out 15: bit 14 = 0 instruction ROM, 1 data memory; [13:0] word address.
- `upg_dat_o` out 32: word data, byte 0 received in [7:0].
- `upg_done_o` out 1: sticky; session finished.
- `upg_tx_o` out 1: UART TX, 8N1, idle high.

## Operation
- Protocol, in bytes:
  - `'I'`(0x49) or `'D'`(0x44), then count N as 2 bytes little-endian (1..16384), then 4N payload bytes.
  - `'E'`(0x45) ends the session.
- FSM states:
  - CMD: `'I'`/`'D'` latches segment bit (0/1) and goes to CNT_LO. `'E'` goes to DONE. Any other byte sends `'N'`(0x4E) and stays in CMD.
  - CNT_LO → CNT_HI.
  - CNT_HI: N=0 or N>16384 sends `'N'` and returns to CMD. Otherwise clears word address to 0 and byte index to 0, then goes to PAYLOAD.
  - PAYLOAD: shifts byte into lane [8*idx +: 8]. At idx=3 it pulses `upg_wen_o`, increments the address and decrements the remaining count. When remaining reaches 0 it sends `'K'`(0x4B) and goes to CMD.
  - DONE: sets `upg_done_o`, sends `'K'`, and ignores all further RX until reset.
- A segment may be repeated. Every segment restarts at word address 0.
- Framing error (stop bit sampled 0): byte discarded, partial word discarded, `'N'` sent, FSM → CMD. `upg_wen_o` never fires for a corrupted word.
- Word address is 14 bits. No wrap-around is reachable because N ≤ 16384.

## Timing
- Reset values:
  - `upg_wen_o`=0, `upg_adr_o`=0, `upg_dat_o`=0, `upg_done_o`=0, `upg_tx_o`=1.
  - FSM=CMD; RX and TX idle; pending ack empty.
- Reset mid-operation aborts everything next edge: partial word dropped, TX line forced high mid-byte.
- RX path:
  - 2-flop synchronizer on `upg_rx_i`.
  - Start is detected on the synchronized falling edge and re-checked at CLKS_PER_BIT/2. If high at that point, it was a glitch: return to idle.
  - Data bits sampled every CLKS_PER_BIT, LSB first. Stop bit is sampled mid-bit.
  - `rx_valid` pulses 1 cycle at the stop-bit sample.
- Write timing:
  - `upg_wen_o` asserts the cycle after the `rx_valid` of the 4th byte, i.e. 1-cycle latency.
  - `upg_adr_o`/`upg_dat_o` are valid in that cycle and held until the next strobe.
  - The address increment is visible from the following cycle.
- `upg_done_o` rises the cycle after `'E'`'s `rx_valid` and stays high until reset.
- TX path:
  - Start bit begins the cycle after an ack request; each bit lasts CLKS_PER_BIT; frame is 10 bits.
  - 1-entry pending register: a request while busy is held and sent back-to-back.
  - Further requests while pending is full are dropped.
- Simultaneous ack request and TX completion in the same cycle: the request goes straight into the TX shifter, not into pending.

## Structure
- Package `upg_pkg`: command constants (`CMD_I`, `CMD_D`, `CMD_E`, `ACK_K`, `ACK_N`), FSM state enum, `MAX_WORDS`=16384.
- Sub-module `uart_rx_byte`:
  - Synchronizer, bit timer, shifter.
  - Outputs `rx_data[7:0]`, `rx_valid`, `rx_ferr`.
- TX serializer and pending register stay inline in the top module.

## Test plan
- CLKS_PER_BIT=8. Send `49 02 00 78 56 34 12 EF BE AD DE 45`. Expect:
  - `wen` pulses with (adr=0x0000, dat=0x12345678), then (0x0001, 0xDEADBEEF).
  - TX emits 0x4B; then `upg_done_o`=1 and TX emits 0x4B again.
- Send `44 01 00 AA BB CC DD` → one strobe with adr=0x4000, dat=0xDDCCBBAA, then TX 0x4B.
- Send 0x33 in CMD → TX 0x4E, no strobe, FSM stays in CMD. Send `49 00 00` → TX 0x4E.
- Send byte with stop bit = 0 during the 2nd payload byte → TX 0x4E, no strobe. A following valid `'I'` segment loads normally from adr 0.
- Pulse `upg_rx_i` low for 2 cycles (glitch) → no `rx_valid`.
- Assert `upg_rst_i` after 2 payload bytes → all outputs at reset values next cycle. After that, a full `'I'` segment works from adr 0.
- After `upg_done_o`=1, send `49 01 00 …` → no strobe, no TX, done stays 1.

Source files
------------

// File: rtl/upg_pkg.sv
// Shared constants and FSM encoding for the UART programming loader.
package upg_pkg;

  localparam logic [7:0] CMD_I = 8'h49;
  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] CMD_E = 8'h45;
  localparam logic [7:0] ACK_K = 8'h4B;
  localparam logic [7:0] ACK_N = 8'h4E;

  localparam int unsigned MAX_WORDS = 16384;

  localparam logic [2:0] ST_CMD     = 3'd0;
  localparam logic [2:0] ST_CNT_LO  = 3'd1;
  localparam logic [2:0] ST_CNT_HI  = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    S_CMD     = ST_CMD,
    S_CNT_LO  = ST_CNT_LO,
    S_CNT_HI  = ST_CNT_HI,
    S_PAYLOAD = ST_PAYLOAD,
    S_DONE    = ST_DONE
  } upg_state_e;

  function automatic logic count_ok(input logic [15:0] n);
    return (n != 16'd0) && (n <= 16'(MAX_WORDS));
  endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// Received-byte channel between the RX deserializer and the loader FSM.
interface uart_prog_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;

  modport master (output rx_data, output rx_valid, output rx_ferr);
  modport slave  (input  rx_data, input  rx_valid, input  rx_ferr);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, glitch-rejecting start.
module uart_rx_byte
  import upg_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 78
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      rx_i,
  uart_prog_loader_if.master        rx
);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  logic [1:0]  sync_q;
  logic        prev_q;
  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        rx_s;

  assign rx_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          valid_d = rx_s;
          ferr_d  = !rx_s;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      prev_q  <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx.rx_data  = shift_q;
  assign rx.rx_valid = valid_q;
  assign rx.rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// UART programming loader: command FSM, word assembly, write strobes and ack TX.
module uart_prog_loader
  import upg_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 78
) (
  input  logic        upg_clk_i,
  input  logic        upg_rst_i,
  input  logic        upg_rx_i,
  output logic        upg_clk_o,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        upg_tx_o
);

  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  uart_prog_loader_if rx_bus ();

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i (upg_clk_i),
    .rst_i (upg_rst_i),
    .rx_i  (upg_rx_i),
    .rx    (rx_bus)
  );

  upg_state_e  state_q, state_d;
  logic        seg_q, seg_d;
  logic [7:0]  cnt_lo_q, cnt_lo_d;
  logic [14:0] remain_q, remain_d;
  logic [13:0] wadr_q, wadr_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] word_q, word_d;
  logic        wen_q, wen_d;
  logic [14:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        done_q, done_d;
  logic        ack_req;
  logic [7:0]  ack_byte;
  logic [15:0] cnt_w;
  logic [7:0]  rxd;

  assign rxd   = rx_bus.rx_data;
  assign cnt_w = {rxd, cnt_lo_q};

  always_comb begin
    state_d  = state_q;
    seg_d    = seg_q;
    cnt_lo_d = cnt_lo_q;
    remain_d = remain_q;
    wadr_d   = wadr_q;
    idx_d    = idx_q;
    word_d   = word_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    done_d   = done_q;
    wen_d    = 1'b0;
    ack_req  = 1'b0;
    ack_byte = ACK_N;
    // A framing error anywhere outside DONE discards the partial word and resyncs on a command.
    if (rx_bus.rx_ferr && state_q != S_DONE) begin
      ack_req = 1'b1;
      state_d = S_CMD;
      idx_d   = '0;
    end else if (rx_bus.rx_valid) begin
      case (state_q)
        S_CMD: begin
          if (rxd == CMD_I || rxd == CMD_D) begin
            seg_d   = (rxd == CMD_D);
            state_d = S_CNT_LO;
          end else if (rxd == CMD_E) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            ack_req  = 1'b1;
            ack_byte = ACK_K;
          end else begin
            ack_req = 1'b1;
          end
        end
        S_CNT_LO: begin
          cnt_lo_d = rxd;
          state_d  = S_CNT_HI;
        end
        S_CNT_HI: begin
          if (count_ok(cnt_w)) begin
            remain_d = cnt_w[14:0];
            wadr_d   = '0;
            idx_d    = '0;
            state_d  = S_PAYLOAD;
          end else begin
            ack_req = 1'b1;
            state_d = S_CMD;
          end
        end
        S_PAYLOAD: begin
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0: word_d[7:0]   = rxd;
            2'd1: word_d[15:8]  = rxd;
            2'd2: word_d[23:16] = rxd;
            default: begin
              wen_d    = 1'b1;
              adr_d    = {seg_q, wadr_q};
              dat_d    = {rxd, word_q};
              wadr_d   = wadr_q + 14'd1;
              remain_d = remain_q - 15'd1;
              if (remain_q == 15'd1) begin
                ack_req  = 1'b1;
                ack_byte = ACK_K;
                state_d  = S_CMD;
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      state_q  <= S_CMD;
      seg_q    <= 1'b0;
      cnt_lo_q <= '0;
      remain_q <= '0;
      wadr_q   <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      wen_q    <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      seg_q    <= seg_d;
      cnt_lo_q <= cnt_lo_d;
      remain_q <= remain_d;
      wadr_q   <= wadr_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      wen_q    <= wen_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      done_q   <= done_d;
    end
  end

  logic        tx_busy_q, tx_busy_d;
  logic [8:0]  tx_shift_q, tx_shift_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic        tx_q, tx_d;
  logic        pend_vld_q, pend_vld_d;
  logic [7:0]  pend_q, pend_d;
  logic        tx_tick, tx_free, load_en;
  logic [7:0]  load_byte;

  assign tx_tick = tx_busy_q && (tx_cnt_q == FULL_M1);
  assign tx_free = !tx_busy_q || (tx_tick && tx_bit_q == 4'd9);

  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_d       = tx_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    load_en    = 1'b0;
    load_byte  = ack_byte;
    // Pending ack wins the free shifter; a same-cycle request then takes its place.
    if (tx_free) begin
      if (pend_vld_q) begin
        load_en    = 1'b1;
        load_byte  = pend_q;
        pend_vld_d = ack_req;
        if (ack_req) pend_d = ack_byte;
      end else if (ack_req) begin
        load_en = 1'b1;
      end else begin
        tx_busy_d = 1'b0;
        tx_d      = 1'b1;
      end
    end else begin
      if (tx_tick) begin
        tx_cnt_d   = '0;
        tx_bit_d   = tx_bit_q + 4'd1;
        tx_d       = tx_shift_q[0];
        tx_shift_d = {1'b1, tx_shift_q[8:1]};
      end else begin
        tx_cnt_d = tx_cnt_q + 16'd1;
      end
      if (ack_req && !pend_vld_q) begin
        pend_vld_d = 1'b1;
        pend_d     = ack_byte;
      end
    end
    if (load_en) begin
      tx_busy_d  = 1'b1;
      tx_d       = 1'b0;
      tx_shift_d = {1'b1, load_byte};
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
    end
  end

  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
    end
  end

  assign upg_clk_o  = upg_clk_i;
  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = done_q;
  assign upg_tx_o   = tx_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: byte-level RX stimulus, strobe and ack recorders.
module tb_uart_prog_loader;

  localparam int unsigned CPB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        clk_o, wen, done, tx;
  logic [14:0] adr;
  logic [31:0] dat;

  int checks = 0;
  int errors = 0;

  logic [46:0] wq[$];
  logic [7:0]  tq[$];

  always #5 clk = ~clk;

  uart_prog_loader #(.CLKS_PER_BIT(CPB)) dut (
    .upg_clk_i  (clk),
    .upg_rst_i  (rst),
    .upg_rx_i   (rx),
    .upg_clk_o  (clk_o),
    .upg_wen_o  (wen),
    .upg_adr_o  (adr),
    .upg_dat_o  (dat),
    .upg_done_o (done),
    .upg_tx_o   (tx)
  );

  always @(negedge clk) begin
    if (wen === 1'b1) wq.push_back({adr, dat});
  end

  initial begin : tx_mon
    logic [7:0] b;
    b = '0;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        tq.push_back(b);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] c, input logic [15:0] n);
    send_byte(c, 1'b1);
    send_byte(n[7:0], 1'b1);
    send_byte(n[15:8], 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic expect_wen(input string tag, input logic [14:0] a, input logic [31:0] d);
    logic [46:0] e;
    chk({tag, "_wen"}, 64'(wq.size() > 0), 64'd1);
    if (wq.size() > 0) begin
      e = wq.pop_front();
      chk({tag, "_adr"}, 64'(e[46:32]), 64'(a));
      chk({tag, "_dat"}, 64'(e[31:0]), 64'(d));
    end
  endtask

  task automatic finish_step(input string tag, input int nacks, input logic [7:0] ack);
    chk({tag, "_extra_wen"}, 64'(wq.size()), 64'd0);
    chk({tag, "_nacks"}, 64'(tq.size()), 64'(nacks));
    while (tq.size() > 0) chk({tag, "_ack"}, 64'(tq.pop_front()), 64'(ack));
    wq.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wen"},  64'(wen),  64'd0);
    chk({tag, "_adr"},  64'(adr),  64'd0);
    chk({tag, "_dat"},  64'(dat),  64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_tx"},   64'(tx),   64'd1);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    idle(4);
    chk_reset_vals("por");
    rst = 1'b0;
    idle(5);

    // Two-word instruction segment, then end of session.
    send_hdr(8'h49, 16'd2);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    idle(100);
    expect_wen("segI_w0", 15'h0000, 32'h12345678);
    expect_wen("segI_w1", 15'h0001, 32'hDEADBEEF);
    chk("segI_done_low", 64'(done), 64'd0);
    finish_step("segI", 1, 8'h4B);
    send_byte(8'h45, 1'b1);
    idle(100);
    chk("end_done", 64'(done), 64'd1);
    finish_step("end", 1, 8'h4B);

    rst = 1'b1;
    idle(2);
    chk_reset_vals("rst_after_done");
    rst = 1'b0;
    idle(5);

    send_hdr(8'h44, 16'd1);
    send_word(32'hDDCCBBAA);
    idle(100);
    expect_wen("segD", 15'h4000, 32'hDDCCBBAA);
    finish_step("segD", 1, 8'h4B);

    send_byte(8'h33, 1'b1);
    idle(100);
    finish_step("badcmd", 1, 8'h4E);

    send_hdr(8'h49, 16'd0);
    idle(100);
    finish_step("cnt0", 1, 8'h4E);

    send_hdr(8'h49, 16'd16385);
    idle(100);
    finish_step("cnt16385", 1, 8'h4E);

    send_hdr(8'h49, 16'd16384);
    idle(100);
    finish_step("cnt16384", 0, 8'h00);
    send_byte(8'h55, 1'b0);
    idle(100);
    finish_step("cnt16384_ferr", 1, 8'h4E);

    // Corrupted second payload byte, then a clean segment from address 0.
    send_hdr(8'h49, 16'd1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b0);
    idle(100);
    finish_step("ferr", 1, 8'h4E);
    send_hdr(8'h49, 16'd1);
    send_word(32'h44332211);
    idle(100);
    expect_wen("ferr_recover", 15'h0000, 32'h44332211);
    finish_step("ferr_recover", 1, 8'h4B);

    send_byte(8'h33, 1'b1);
    send_byte(8'h34, 1'b1);
    idle(180);
    finish_step("b2b", 2, 8'h4E);

    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(120);
    finish_step("glitch", 0, 8'h00);

    // Reset mid-word: one full data word, then two bytes of the next.
    send_hdr(8'h44, 16'd2);
    send_word(32'hDDCCBBAA);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    expect_wen("pre_rst", 15'h4000, 32'hDDCCBBAA);
    rst = 1'b1;
    idle(1);
    chk_reset_vals("mid_rst");
    rst = 1'b0;
    idle(5);
    finish_step("mid_rst", 0, 8'h00);
    send_hdr(8'h49, 16'd1);
    send_word(32'h04030201);
    idle(100);
    expect_wen("post_rst", 15'h0000, 32'h04030201);
    finish_step("post_rst", 1, 8'h4B);

    send_byte(8'h45, 1'b1);
    idle(100);
    chk("sticky_done_set", 64'(done), 64'd1);
    finish_step("sticky_end", 1, 8'h4B);
    send_hdr(8'h49, 16'd1);
    send_word(32'h04030201);
    idle(100);
    chk("sticky_done_hold", 64'(done), 64'd1);
    finish_step("sticky_ignore", 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
